// File: rtl/kb_pkg.sv
// Shared scan-code constants, FSM states and key-state types for the keyboard
// scan sequencer.
package kb_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_SEMI  = 8'h4C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kb_state_e;

  typedef struct packed {
    logic shoot;
    logic right;
    logic left;
    logic down;
    logic up;
  } keys_t;

  typedef struct packed {
    keys_t p2;
    keys_t p1;
  } held_t;

  // One-hot held-bit mask for a final byte; extended bytes map only P2 arrows.
  function automatic held_t key_mask(input logic [7:0] c, input logic ext);
    held_t m;
    m = '0;
    if (ext) begin
      case (c)
        SC_UP:    m.p2.up    = 1'b1;
        SC_DOWN:  m.p2.down  = 1'b1;
        SC_LEFT:  m.p2.left  = 1'b1;
        SC_RIGHT: m.p2.right = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (c)
        SC_W:    m.p1.up    = 1'b1;
        SC_S:    m.p1.down  = 1'b1;
        SC_A:    m.p1.left  = 1'b1;
        SC_D:    m.p1.right = 1'b1;
        SC_J:    m.p1.shoot = 1'b1;
        SC_SEMI: m.p2.shoot = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // Opposing directions cancel: {right, left, down, up}.
  function automatic logic [3:0] dir_out(input keys_t k);
    return {k.right & ~k.left, k.left & ~k.right, k.down & ~k.up, k.up & ~k.down};
  endfunction

endpackage

// File: rtl/kb_scan_ctrl_fire_limiter.sv
// Shoot-key rate limiter: one-cycle fire pulse when held and cooled down,
// auto-repeating every FIRE_COOLDOWN cycles while held.
module fire_limiter #(
  parameter int unsigned FIRE_COOLDOWN = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic held,
  output logic pulse
);

  localparam int unsigned CW = $clog2(FIRE_COOLDOWN);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (held && cnt == '0) begin
        pulse <= 1'b1;
        cnt   <= CW'(FIRE_COOLDOWN - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/kb_scan_ctrl.sv
// PS/2 set-2 scan-code sequencer: E0/F0 prefix FSM, held-key state for two
// players, opposing-direction masking and per-player fire limiting.
module kb_scan_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIRE_COOLDOWN  = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic       proto_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  kb_state_e state, state_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic err_d;
  logic key_ev_c, key_brk_c, key_ext_c;
  logic is_prefix_c;
  held_t held, held_d, mask_c;
  logic [3:0] dir1, dir2;
  logic fire1, fire2;

  assign is_prefix_c = (code == SC_EXT) || (code == SC_BRK);

  // Prefix FSM and timeout; a strobe always wins over the timeout.
  always_comb begin
    state_d   = state;
    tcnt_d    = '0;
    err_d     = 1'b0;
    key_ev_c  = 1'b0;
    key_brk_c = 1'b0;
    key_ext_c = 1'b0;
    if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (code == SC_EXT)      state_d = ST_EXT;
          else if (code == SC_BRK) state_d = ST_BRK;
          else                     key_ev_c = 1'b1;
        end
        ST_EXT: begin
          if (code == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (code == SC_EXT) begin
            err_d = 1'b1;
          end else begin
            key_ev_c  = 1'b1;
            key_ext_c = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (is_prefix_c) err_d = 1'b1;
          else begin
            key_ev_c  = 1'b1;
            key_brk_c = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (is_prefix_c) err_d = 1'b1;
          else begin
            key_ev_c  = 1'b1;
            key_brk_c = 1'b1;
            key_ext_c = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        tcnt_d = tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_d;
      tcnt      <= tcnt_d;
      proto_err <= err_d;
    end
  end

  // Held-key update: make sets, break clears, unmapped codes give an empty mask.
  always_comb begin
    mask_c = key_mask(code, key_ext_c);
    held_d = held;
    if (key_ev_c) begin
      if (key_brk_c) held_d = held_t'(held & ~mask_c);
      else           held_d = held_t'(held | mask_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
      dir1 <= '0;
      dir2 <= '0;
    end else begin
      held <= held_d;
      dir1 <= dir_out(held_d.p1);
      dir2 <= dir_out(held_d.p2);
    end
  end

  fire_limiter #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_fire1 (
    .clk   (clk),
    .rst   (rst),
    .held  (held.p1.shoot),
    .pulse (fire1)
  );

  fire_limiter #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_fire2 (
    .clk   (clk),
    .rst   (rst),
    .held  (held.p2.shoot),
    .pulse (fire2)
  );

  assign p1 = {fire1, dir1};
  assign p2 = {fire2, dir2};

endmodule

// File: doc/kb_scan_ctrl.md
# kb_scan_ctrl

Scan-code sequencer between the PS/2 byte receiver and the game logic. Consumes the raw set-2 byte stream, decodes E0 (extended) and F0 (break) prefixes with a small FSM, and maintains held-key state for both players. It also rate-limits each player's shoot key into single-cycle fire pulses with auto-repeat. It replaces ad-hoc per-byte key mapping, so key release and the extended arrow keys work correctly.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 100000: idle cycles after which a pending prefix is abandoned.
- `FIRE_COOLDOWN`, default 2500000: minimum cycles between fire pulses per player. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock. All logic is on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `code`  in  8  received scan-code byte.
- `code_valid`  in  1  one-cycle strobe; `code` is valid in this cycle.
- `p1`  out  5  bits [0] up, [1] down, [2] left, [3] right (held levels), [4] fire pulse.
- `p2`  out  5  same layout as `p1`, for player 2.
- `proto_err`  out  1  one-cycle pulse on a malformed sequence or prefix timeout.

## Operation

- Key map, non-extended:
  - P1: W 1D→up, S 1B→down, A 1C→left, D 23→right, J 3B→shoot.
  - P2: ; 4C→shoot.
- Key map, extended (E0-prefixed only): P2 arrows E0 75→up, E0 72→down, E0 6B→left, E0 74→right. The non-extended 75/72/6B/74 (keypad) codes are unmapped and ignored.
- FSM states are IDLE, EXT, BRK and EXT_BRK. Each transition below is taken on a `code_valid` cycle:
  - IDLE: E0→EXT; F0→BRK; any other byte→make(code, ext=0), stay in IDLE.
  - EXT: F0→EXT_BRK; any other non-prefix byte→make(code, ext=1), go to IDLE; E0→pulse `proto_err`, stay in EXT.
  - BRK: non-prefix byte→break(code, ext=0), go to IDLE; E0 or F0→pulse `proto_err`, go to IDLE.
  - EXT_BRK: non-prefix byte→break(code, ext=1), go to IDLE; prefix byte→pulse `proto_err`, go to IDLE.
- Make sets the mapped internal held bit; break clears it. Unmapped codes change nothing. E1 is handled as an ordinary unmapped byte.
- Typematic repeat makes of an already-held key have no effect on held state.
- Direction output is `held & ~opposite_held`: if up and down are both held, both output 0; left/right behave the same way.
- Fire limiter, one per player:
  - A counter loads FIRE_COOLDOWN−1 on each pulse and decrements to 0.
  - When shoot is held and the counter is 0, emit a 1-cycle pulse.
  - Holding shoot therefore auto-fires every FIRE_COOLDOWN cycles.
- Prefix timeout:
  - A counter increments in any non-IDLE state on cycles without `code_valid`, and clears on `code_valid` or in IDLE.
  - At TIMEOUT_CYCLES−1 the FSM goes to IDLE and pulses `proto_err`.

## Timing

- Reset values: `p1`, `p2` and `proto_err` are 0; FSM is IDLE; all held bits, cooldown counters and timeout counter are 0.
- Held direction bits appear on the outputs 1 cycle after the `code_valid` of the final byte of the sequence.
- Fire pulse on a fresh press with an idle cooldown: `p*[4]` is high exactly 1 cycle, 2 cycles after the final `code_valid`. One cycle latches held, one cycle is the limiter register.
- Shoot make while the cooldown is nonzero: no immediate pulse. A pulse occurs the cycle after the counter reaches 0, if shoot is still held.
- A shoot break clears held; no pulse is issued after it.
- `code_valid` in the same cycle the timeout would fire: the byte is processed and the timeout is suppressed.
- `code_valid` strobes may arrive back-to-back every cycle. No backpressure is provided.
- Asserting `rst` mid-sequence or mid-cooldown forces all state to its reset value immediately.
- Timeout counter width is $clog2(TIMEOUT_CYCLES). Cooldown counter width is $clog2(FIRE_COOLDOWN).

## Structure

- Shared package `kb_pkg`:
  - scan-code constants for the ten mapped keys;
  - prefix constants `SC_EXT`=8'hE0 and `SC_BRK`=8'hF0;
  - the FSM state enum.
- One sub-module, `fire_limiter` (inputs clk, rst, held; output pulse; parameter FIRE_COOLDOWN), instantiated twice.
- Top-level holds the FSM, the timeout counter, the decode and the opposing-direction masking.

## Test plan

Bench parameters: TIMEOUT_CYCLES=16, FIRE_COOLDOWN=8.

- Bytes 1D, then F0 1D → `p1[0]`=1 one cycle after the 1D strobe; returns to 0 one cycle after the final 1D; `proto_err` never asserts.
- Bytes E0 75, then E0 F0 75 → `p2[0]` rises, then falls. A bare 75 leaves `p2` at 0.
- Bytes 1D then 1B (up and down held) → `p1[1:0]`=00. Then F0 1D → `p1[1:0]`=10.
- Byte 3B held for 20 cycles, then F0 3B → `p1[4]` pulses at final-strobe+2, then every 8 cycles (3 pulses); no pulse after the break.
- Byte F0, then 16 idle cycles → `proto_err` pulses once, FSM returns to IDLE. A following 23 → `p1[3]`=1, i.e. treated as a make.
- Bytes F0 E0 → `proto_err` pulse. Assert `rst` while `p1[0]`=1 and the P1 cooldown is nonzero → all outputs 0 immediately; the next 3B press fires at +2.
